// File: rtl/hazard_flag_pipe_pkg.sv
// Shared definitions for the hazard flag pipeline: stall FSM encoding,
// default sizing constants and flag bit positions within a bundle.
package hazard_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } stall_state_e;

    localparam int HAZ_W     = 2;
    localparam int HAZ_DEPTH = 4;
    localparam int HAZ_CNT_W = 3;

    localparam int FLG_REDIR_DM = 0;
    localparam int FLG_STALL    = 1;

endpackage

// File: rtl/hazard_flag_pipe_if.sv
// Bus bundle for hazard_flag_pipe. The slave modport is the pipeline side,
// the master modport is the instruction source / observer side.
// Optional macro HAZ_PERF_CNT_EN adds the stall_cycles/flush_count outputs.
interface hazard_flag_pipe_if #(
    parameter int W     = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) ();
    logic                 in_valid;
    logic [W-1:0]         in_flags;
    logic                 stall_req;
    logic [CNT_W-1:0]     stall_len;
    logic                 flush;
    logic [DEPTH-1:0]     stg_valid;
    logic [DEPTH*W-1:0]   stg_flags;
    logic                 stall;
    logic                 busy;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]          stall_cycles;
    logic [31:0]          flush_count;
`endif

    modport slave (
        input  in_valid, in_flags, stall_req, stall_len, flush,
`ifdef HAZ_PERF_CNT_EN
        output stall_cycles, flush_count,
`endif
        output stg_valid, stg_flags, stall, busy
    );

    modport master (
        output in_valid, in_flags, stall_req, stall_len, flush,
`ifdef HAZ_PERF_CNT_EN
        input  stall_cycles, flush_count,
`endif
        input  stg_valid, stg_flags, stall, busy
    );
endinterface

// File: rtl/hazard_flag_pipe_stall_seq.sv
// Multi-cycle stall sequencer. A request in IDLE freezes the pipe for
// max(stall_len,1) cycles in total: the request cycle itself plus
// max(stall_len,1)-1 cycles spent in STALL. Flush aborts everything.
module hazard_stall_seq
    import hazard_pkg::*;
#(
    parameter int CNT_W = HAZ_CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             stall_req,
    input  logic [CNT_W-1:0] stall_len,
    input  logic             flush,
    output logic             stall_act,
    output logic             busy
);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    stall_state_e     state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [CNT_W-1:0] len_m1_s;

    // Effective length minus one; a zero length behaves like one.
    always_comb begin
        if (stall_len == CNT_ZERO) begin
            len_m1_s = CNT_ZERO;
        end else begin
            len_m1_s = stall_len - CNT_ONE;
        end
    end

    // State and remaining-cycle counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next state: flush wins, a request in IDLE loads the counter, STALL
    // counts down and leaves when the count reaches zero.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        if (flush) begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (stall_req) begin
                        cnt_s   = len_m1_s;
                        state_s = (len_m1_s != CNT_ZERO) ? ST_STALL : ST_IDLE;
                    end else begin
                        cnt_s   = CNT_ZERO;
                        state_s = ST_IDLE;
                    end
                end
                ST_STALL: begin
                    if (cnt_r <= CNT_ONE) begin
                        cnt_s   = CNT_ZERO;
                        state_s = ST_IDLE;
                    end else begin
                        cnt_s   = cnt_r - CNT_ONE;
                        state_s = ST_STALL;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Stall is active on the request cycle and throughout STALL, never on flush.
    always_comb begin
        busy      = (state_r == ST_STALL);
        stall_act = ~flush & (((state_r == ST_IDLE) & stall_req) | (state_r == ST_STALL));
    end

endmodule

// File: rtl/hazard_flag_pipe.sv
// Control-flag pipeline: DEPTH stages of {valid, flags}, stage 0 youngest.
// Stall holds stages below STALL_STAGE and bubbles STALL_STAGE; flush clears
// stages 0..FLUSH_STAGE. Optional macro HAZ_PERF_CNT_EN adds stall/flush
// event counters.
module hazard_flag_pipe
    import hazard_pkg::*;
#(
    parameter int W           = HAZ_W,
    parameter int DEPTH       = HAZ_DEPTH,
    parameter int STALL_STAGE = 1,
    parameter int FLUSH_STAGE = 1,
    parameter int CNT_W       = HAZ_CNT_W
) (
    input  logic              clk,
    input  logic              resetn,
    hazard_flag_pipe_if.slave bus
);
    localparam logic [W-1:0] FLG_ZERO = {W{1'b0}};

    logic         stall_act_s;
    logic         busy_s;
    logic         stall_r;
    logic         valid_r [DEPTH];
    logic [W-1:0] flags_r [DEPTH];
    logic         valid_s [DEPTH];
    logic [W-1:0] flags_s [DEPTH];

    hazard_stall_seq #(.CNT_W(CNT_W)) u_seq (
        .clk       (clk),
        .resetn    (resetn),
        .stall_req (bus.stall_req),
        .stall_len (bus.stall_len),
        .flush     (bus.flush),
        .stall_act (stall_act_s),
        .busy      (busy_s)
    );

    // Next value of every stage: flush clear, stall hold/bubble, else shift.
    always_comb begin
        valid_s[0] = valid_r[0];
        flags_s[0] = flags_r[0];
        if (bus.flush) begin
            valid_s[0] = 1'b0;
            flags_s[0] = FLG_ZERO;
        end else if (stall_act_s) begin
            if (STALL_STAGE == 0) begin
                valid_s[0] = 1'b0;
                flags_s[0] = FLG_ZERO;
            end else begin
                valid_s[0] = valid_r[0];
                flags_s[0] = flags_r[0];
            end
        end else begin
            valid_s[0] = bus.in_valid;
            flags_s[0] = bus.in_valid ? bus.in_flags : FLG_ZERO;
        end
        for (int i = 1; i < DEPTH; i++) begin
            valid_s[i] = valid_r[i-1];
            flags_s[i] = flags_r[i-1];
            if (bus.flush && (i <= FLUSH_STAGE)) begin
                valid_s[i] = 1'b0;
                flags_s[i] = FLG_ZERO;
            end else if (stall_act_s && (i < STALL_STAGE)) begin
                valid_s[i] = valid_r[i];
                flags_s[i] = flags_r[i];
            end else if (stall_act_s && (i == STALL_STAGE)) begin
                valid_s[i] = 1'b0;
                flags_s[i] = FLG_ZERO;
            end else begin
                valid_s[i] = valid_r[i-1];
                flags_s[i] = flags_r[i-1];
            end
        end
    end

    // Stage registers and the one-cycle-delayed stall indication.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= 1'b0;
                flags_r[i] <= FLG_ZERO;
            end
            stall_r <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= valid_s[i];
                flags_r[i] <= flags_s[i];
            end
            stall_r <= stall_act_s;
        end
    end

    // Flatten stage registers onto the bus.
    always_comb begin
        bus.stg_valid = {DEPTH{1'b0}};
        bus.stg_flags = {(DEPTH*W){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            bus.stg_valid[i]       = valid_r[i];
            bus.stg_flags[i*W +: W] = flags_r[i];
        end
        bus.stall = stall_r;
        bus.busy  = busy_s;
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles_r;
    logic [31:0] flush_count_r;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles_r <= 32'd0;
            flush_count_r  <= 32'd0;
        end else begin
            stall_cycles_r <= stall_cycles_r + (stall_act_s ? 32'd1 : 32'd0);
            flush_count_r  <= flush_count_r + (bus.flush ? 32'd1 : 32'd0);
        end
    end

    // Drive counter outputs.
    always_comb begin
        bus.stall_cycles = stall_cycles_r;
        bus.flush_count  = flush_count_r;
    end
`endif

endmodule
